// File: rtl/reg_ctx_sequencer_if.sv
// Handshake/bus bundle between the context sequencer, the register file,
// the register memory and the CPU control unit.
interface reg_ctx_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CTX_W  = 2
);
    logic                    save_req;
    logic                    restore_req;
    logic [CTX_W-1:0]        ctx_id;

    logic [ADDR_W-1:0]       rf_raddr;
    logic [DATA_W-1:0]       rf_rdata;
    logic                    rf_write;
    logic [ADDR_W-1:0]       rf_waddr;
    logic [DATA_W-1:0]       rf_wdata;

    logic                    rm_read;
    logic                    rm_write;
    logic [CTX_W+ADDR_W-1:0] rm_addr;
    logic [DATA_W-1:0]       rm_wdata;
    logic [DATA_W-1:0]       rm_rdata;
    logic                    rm_busywait;

    logic                    busywait;
    logic                    done;

    modport master (
        input  save_req, restore_req, ctx_id,
        input  rf_rdata, rm_rdata, rm_busywait,
        output rf_raddr, rf_write, rf_waddr, rf_wdata,
        output rm_read, rm_write, rm_addr, rm_wdata,
        output busywait, done
    );

    modport slave (
        output save_req, restore_req, ctx_id,
        output rf_rdata, rm_rdata, rm_busywait,
        input  rf_raddr, rf_write, rf_waddr, rf_wdata,
        input  rm_read, rm_write, rm_addr, rm_wdata,
        input  busywait, done
    );
endinterface

// File: rtl/reg_ctx_sequencer.sv
// Register-file context save/restore sequencer: streams x1..x31 between
// the register file and one slot of register memory, stalling the pipe.
module reg_ctx_sequencer #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int CTX_W    = 2
) (
    input  logic                clk,
    input  logic                reset,
    reg_ctx_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAVE,
        ST_RESTORE,
        ST_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

    state_t             state;
    state_t             state_n;
    logic [ADDR_W-1:0]  idx;
    logic [ADDR_W-1:0]  idx_n;
    logic [CTX_W-1:0]   ctx;
    logic [CTX_W-1:0]   ctx_n;

    // State, register index and latched context slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            idx   <= FIRST;
            ctx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            ctx   <= ctx_n;
        end
    end

    // Next-state and Mealy outputs; idx holds at the last register so it never wraps.
    always_comb begin
        state_n         = state;
        idx_n           = idx;
        ctx_n           = ctx;
        bus.rf_raddr    = '0;
        bus.rf_write    = 1'b0;
        bus.rf_waddr    = '0;
        bus.rf_wdata    = '0;
        bus.rm_read     = 1'b0;
        bus.rm_write    = 1'b0;
        bus.rm_addr     = '0;
        bus.rm_wdata    = '0;
        bus.busywait    = 1'b0;
        bus.done        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.save_req) begin
                    state_n = ST_SAVE;
                    idx_n   = FIRST;
                    ctx_n   = bus.ctx_id;
                end else if (bus.restore_req) begin
                    state_n = ST_RESTORE;
                    idx_n   = FIRST;
                    ctx_n   = bus.ctx_id;
                end
            end
            ST_SAVE: begin
                bus.busywait = 1'b1;
                bus.rf_raddr = idx;
                bus.rm_write = 1'b1;
                bus.rm_addr  = {ctx, idx};
                bus.rm_wdata = bus.rf_rdata;
                if (!bus.rm_busywait) begin
                    if (idx == LAST) begin
                        state_n = ST_DONE;
                    end else begin
                        idx_n = idx + FIRST;
                    end
                end
            end
            ST_RESTORE: begin
                bus.busywait = 1'b1;
                bus.rm_read  = 1'b1;
                bus.rm_addr  = {ctx, idx};
                if (!bus.rm_busywait) begin
                    bus.rf_write = 1'b1;
                    bus.rf_waddr = idx;
                    bus.rf_wdata = bus.rm_rdata;
                    if (idx == LAST) begin
                        state_n = ST_DONE;
                    end else begin
                        idx_n = idx + FIRST;
                    end
                end
            end
            ST_DONE: begin
                bus.done = 1'b1;
                state_n  = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_reg_ctx_sequencer.sv
// Bench for reg_ctx_sequencer: behavioural RF/RM environment, per-slot
// image model, directed scenarios plus randomized stall rounds.
module tb_reg_ctx_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   rd_cnt      = 0;
    int   wr_cnt      = 0;

    logic [31:0] rf_mem [32];
    logic [31:0] rm_mem [128];
    logic [31:0] img    [4][32];

    reg_ctx_sequencer_if b ();

    reg_ctx_sequencer dut (
        .clk   (clk),
        .reset (rst),
        .bus   (b)
    );

    always #5 clk = ~clk;

    assign b.rf_rdata = rf_mem[b.rf_raddr];
    assign b.rm_rdata = rm_mem[b.rm_addr];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ctl"},
            64'({b.busywait, b.done, b.rm_read, b.rm_write, b.rf_write,
                 b.rf_raddr, b.rf_waddr, b.rm_addr}), 64'(0));
        chk({tag, ".data"}, {b.rm_wdata, b.rf_wdata}, 64'(0));
    endtask

    // Environment: capture outputs before the edge, commit memories after it.
    task automatic step();
        logic        rfw, rmw;
        logic [4:0]  rfa;
        logic [6:0]  rma;
        logic [31:0] rfd, rmd;
        rfw = b.rf_write;
        rfa = b.rf_waddr;
        rfd = b.rf_wdata;
        rmw = b.rm_write && !b.rm_busywait;
        rma = b.rm_addr;
        rmd = b.rm_wdata;
        if (b.rm_read) rd_cnt++;
        if (rmw) wr_cnt++;
        @(posedge clk);
        if (rfw) rf_mem[rfa] = rfd;
        if (rmw) rm_mem[rma] = rmd;
        #1;
    endtask

    task automatic check_rm(input string tag);
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 32; i++)
                chk(tag, 64'(rm_mem[c*32+i]), 64'(img[c][i]));
    endtask

    task automatic check_rf(input logic [1:0] c, input string tag);
        chk({tag, ".x0"}, 64'(rf_mem[0]), 64'h0000_0000_C0FF_EE00);
        for (int i = 1; i < 32; i++)
            chk(tag, 64'(rf_mem[i]), 64'(img[c][i]));
    endtask

    task automatic rand_rf();
        for (int i = 1; i < 32; i++) rf_mem[i] = $urandom;
    endtask

    // mode: 0 no stalls, 1 random stalls, 2 three stalls at x7,
    // 3 restore pulse mid-transfer. abort_at>0 drops reset at that idx.
    task automatic run_op(input bit sv, input bit rs, input bit hold,
                          input logic [1:0] c, input int mode,
                          input int abort_at);
        int m_idx, stalls, n, st7, wr0;
        bit busy, is_save;
        is_save = sv;
        b.save_req    = sv;
        b.restore_req = rs;
        b.ctx_id      = c;
        b.rm_busywait = 1'b0;
        if (is_save)
            for (int i = 1; i < 32; i++) img[c][i] = rf_mem[i];
        wr0 = wr_cnt;
        #1;
        step();
        if (!hold) begin
            b.save_req    = 1'b0;
            b.restore_req = 1'b0;
        end
        b.ctx_id = ~c;
        m_idx  = 1;
        stalls = 0;
        n      = 0;
        st7    = 0;
        while (b.done !== 1'b1 && n < 100) begin
            if (m_idx == abort_at) begin
                rst = 1'b0;
                #1;
                chk_idle("abort");
                return;
            end
            case (mode)
                1:       busy = ($urandom_range(3) == 0);
                2:       busy = (m_idx == 7 && st7 < 3);
                default: busy = 1'b0;
            endcase
            if (busy && mode == 2) st7++;
            b.rm_busywait = busy;
            if (mode == 3) b.restore_req = (n == 10);
            #1;
            chk("xfer.bw", 64'(b.busywait), 64'(1));
            chk("xfer.addr", 64'(b.rm_addr), 64'({c, m_idx[4:0]}));
            if (is_save) begin
                chk("save.strb", 64'({b.rm_write, b.rm_read, b.rf_write}),
                    64'(3'b100));
                chk("save.wdata", 64'(b.rm_wdata), 64'(rf_mem[m_idx[4:0]]));
            end else begin
                chk("rest.strb", 64'({b.rm_write, b.rm_read, b.rf_write}),
                    64'({2'b01, !busy}));
                if (!busy)
                    chk("rest.wr", 64'({b.rf_waddr, b.rf_wdata}),
                        64'({m_idx[4:0], rm_mem[{c, m_idx[4:0]}]}));
            end
            if (busy) stalls++;
            else m_idx++;
            n++;
            step();
        end
        b.rm_busywait = 1'b0;
        b.restore_req = 1'b0;
        #1;
        chk("done.lat", 64'(n), 64'(31 + stalls));
        chk("done.pulse",
            64'({b.done, b.busywait, b.rm_write, b.rm_read, b.rf_write}),
            64'(5'b10000));
        if (is_save) chk("save.count", 64'(wr_cnt - wr0), 64'(31));
        step();
        chk_idle("post");
    endtask

    initial begin
        int rd0;
        logic [1:0] c;
        rst           = 1'b0;
        b.save_req    = 1'b0;
        b.restore_req = 1'b0;
        b.ctx_id      = '0;
        b.rm_busywait = 1'b0;
        rf_mem[0] = 32'hC0FF_EE00;
        for (int i = 1; i < 32; i++) rf_mem[i] = 32'hA000_0000 + i;
        for (int i = 0; i < 128; i++) rm_mem[i] = 32'h5EED_0000 + i;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 32; i++) img[k][i] = 32'h5EED_0000 + k*32 + i;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        rst = 1'b1;
        step();
        chk_idle("idle");

        // Save ctx 2, then restore it into a cleared RF.
        run_op(1'b1, 1'b0, 1'b0, 2'd2, 0, 0);
        check_rm("t1.rm");
        for (int i = 1; i < 32; i++) rf_mem[i] = '0;
        run_op(1'b0, 1'b1, 1'b0, 2'd2, 0, 0);
        check_rf(2'd2, "t2.rf");

        // Three-cycle RM stall on x7.
        rand_rf();
        run_op(1'b1, 1'b0, 1'b0, 2'd1, 2, 0);
        check_rm("t3.rm");

        // Simultaneous requests plus a stray restore pulse mid-save.
        rd0 = rd_cnt;
        rand_rf();
        run_op(1'b1, 1'b1, 1'b0, 2'd3, 3, 0);
        repeat (3) begin
            chk_idle("t4.idle");
            step();
        end
        chk("t4.noread", 64'(rd_cnt - rd0), 64'(0));
        check_rm("t4.rm");

        // Reset during restore at x10.
        for (int i = 1; i < 32; i++) rf_mem[i] = '0;
        run_op(1'b0, 1'b1, 1'b0, 2'd2, 0, 10);
        step();
        step();
        chk_idle("t5.held");
        rst = 1'b1;
        step();
        chk_idle("t5.idle");
        for (int i = 1; i < 32; i++)
            chk("t5.part", 64'(rf_mem[i]), 64'(i < 10 ? img[2][i] : 32'h0));
        rand_rf();
        run_op(1'b1, 1'b0, 1'b0, 2'd0, 1, 0);
        check_rm("t5.rm");

        // Back-to-back saves with SAVE_REQ held, new slot re-latched.
        rand_rf();
        run_op(1'b1, 1'b0, 1'b1, 2'd1, 0, 0);
        rand_rf();
        run_op(1'b1, 1'b0, 1'b1, 2'd3, 0, 0);
        b.save_req = 1'b0;
        step();
        chk_idle("t6.idle");
        check_rm("t6.rm");

        // Randomized save/restore rounds with random stalls.
        repeat (4) begin
            c = 2'($urandom_range(3));
            rand_rf();
            run_op(1'b1, 1'b0, 1'b0, c, 1, 0);
            check_rm("rnd.rm");
            rand_rf();
            run_op(1'b0, 1'b1, 1'b0, c, 1, 0);
            check_rf(c, "rnd.rf");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
